// File: rtl/layer_out_serializer_if.sv
// Handshake bundle between a layer's parallel neuron outputs and the serializer.
// out_ready is present only when SER_READY_EN is defined.
interface layer_out_serializer_if #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
);
  logic                              in_valid;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              out_last;
  logic                              busy;
  logic                              overflow;
`ifdef SER_READY_EN
  logic                              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_data, out_valid, out_last, busy, overflow
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  out_data, out_valid, out_last, busy, overflow
  );
`else
  modport slave (
    input  in_valid, in_data,
    output out_data, out_valid, out_last, busy, overflow
  );
  modport master (
    output in_valid, in_data,
    input  out_data, out_valid, out_last, busy, overflow
  );
`endif
endinterface

// File: rtl/layer_out_serializer.sv
// Serializes a captured vector of NUM_NEURONS words onto a one-word stream.
// Optional SER_READY_EN macro adds out_ready backpressure.
module layer_out_serializer #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  layer_out_serializer_if.slave  bus
);

  localparam int IW = $clog2(NUM_NEURONS + 1);
  localparam int VW = NUM_NEURONS * DATA_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q,    state_d;
  logic [IW-1:0]         index_q,    index_d;
  logic [VW-1:0]         hold_q,     hold_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q,  out_last_d;
  logic                  overflow_q,  overflow_d;

  logic ready;
  logic xfer;
  logic last_xfer;
  logic capture;

`ifdef SER_READY_EN
  assign ready = bus.out_ready;
`else
  assign ready = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;

    xfer      = out_valid_q & ready;
    last_xfer = xfer && (index_q == LAST_IDX);
    // A new vector is accepted when idle or exactly on the last-word transfer.
    capture   = bus.in_valid && ((state_q == IDLE) || last_xfer);

    if (capture) begin
      hold_d      = bus.in_data;
      index_d     = '0;
      state_d     = SHIFT;
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[DATA_WIDTH-1:0];
      out_last_d  = (NUM_NEURONS == 1);
    end else if (last_xfer) begin
      state_d     = IDLE;
      index_d     = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (xfer) begin
      index_d     = index_q + 1'b1;
      out_data_d  = hold_q[int'(index_d)*DATA_WIDTH +: DATA_WIDTH];
      out_last_d  = (index_d == LAST_IDX);
    end

    if (bus.in_valid && (state_q == SHIFT) && !last_xfer) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      index_q     <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.overflow  = overflow_q;

endmodule
